// File: rtl/diff_shift_tx_if.sv
// diff_shift_tx_if: wide packet input stream and narrow beat output stream
// of the diff_shift_tx serializer, grouped as one bundle.
interface diff_shift_tx_if #(
  parameter int unsigned IN_W  = 512,
  parameter int unsigned OUT_W = 16
);
  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  // Producer of packets / consumer of beats.
  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last
  );

  // The serializer itself.
  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, out_last
  );
endinterface

// File: rtl/diff_shift_tx.sv
// diff_shift_tx: accepts one IN_W-bit packet per handshake and emits it as
// IN_W/OUT_W beats of OUT_W bits, most significant word first.
// Optional macro DIFF_SHIFT_TX_SKID_EN adds a one-packet holding register so
// consecutive packets stream without an idle cycle between them.
module diff_shift_tx #(
  parameter int unsigned IN_W  = 512,
  parameter int unsigned OUT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  diff_shift_tx_if.slave bus
);
  localparam int unsigned NBEATS = IN_W / OUT_W;
  localparam int unsigned CTR_W  = $clog2(NBEATS);
  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(NBEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [IN_W-1:0]   shift_q, shift_d;
`ifdef DIFF_SHIFT_TX_SKID_EN
  logic [IN_W-1:0]   hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
`endif

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic last_beat;

  // Handshake qualifiers; in_ready is forced low while reset is asserted.
`ifdef DIFF_SHIFT_TX_SKID_EN
  assign in_ready  = rst && !hold_valid_q && !flush;
`else
  assign in_ready  = rst && (state_q == IDLE) && !flush;
`endif
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = (state_q == SEND) && bus.out_ready;
  assign last_beat = out_fire && (ctr_q == LAST_CTR);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_last  = (state_q == SEND) && (ctr_q == LAST_CTR);
  assign bus.out       = shift_q[IN_W-1 -: OUT_W];

  // Next-state logic: flush overrides any handshake on either side.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    shift_d = shift_q;
`ifdef DIFF_SHIFT_TX_SKID_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif
    if (flush) begin
      state_d = IDLE;
      ctr_d   = '0;
`ifdef DIFF_SHIFT_TX_SKID_EN
      hold_valid_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            shift_d = bus.in;
            ctr_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (out_fire) begin
            shift_d = shift_q << OUT_W;
            ctr_d   = ctr_q + 1'b1;
          end
`ifdef DIFF_SHIFT_TX_SKID_EN
          // On the final beat the next packet comes from the holding register
          // if one is waiting, else straight from the input if it arrives now.
          if (last_beat) begin
            if (hold_valid_q) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
              ctr_d        = '0;
            end else if (in_fire) begin
              shift_d = bus.in;
              ctr_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else if (in_fire) begin
            hold_d       = bus.in;
            hold_valid_d = 1'b1;
          end
`else
          if (last_beat) begin
            state_d = IDLE;
          end
`endif
        end
      endcase
    end
  end

  // State, counter and data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      shift_q <= '0;
`ifdef DIFF_SHIFT_TX_SKID_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      shift_q <= shift_d;
`ifdef DIFF_SHIFT_TX_SKID_EN
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end
endmodule

// File: tb/tb_diff_shift_tx.sv
// tb_diff_shift_tx: scoreboard bench for diff_shift_tx; expected beats are
// queued when a packet is accepted and popped as beats are consumed.
module tb_diff_shift_tx;
  localparam int unsigned IN_W  = 512;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned NB    = IN_W / OUT_W;
`ifdef DIFF_SHIFT_TX_SKID_EN
  localparam int B2B_SPAN = 64;
  localparam int B_OFF    = 1;
`else
  localparam int B2B_SPAN = 65;
  localparam int B_OFF    = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush = 1'b0;

  diff_shift_tx_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  diff_shift_tx #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0]     exp_q[$];
  logic [IN_W-1:0] rt_q[$];
  int beat_cnt  = 0;
  int first_cyc = 0;
  int last_cyc  = 0;

  // Monitor: scoreboard compare, stall stability and packet reassembly.
  logic [OUT_W-1:0] prev_out;
  logic             prev_last;
  logic             prev_stall = 1'b0;
  logic [IN_W-1:0]  rx_word = '0;
  int               rx_n = 0;
  logic [16:0]      e;
  logic [IN_W-1:0]  p;

  always @(negedge clk) begin
    if (rst && !flush) begin
      if (prev_stall) begin
        tests++;
        if (!bus.out_valid || bus.out !== prev_out || bus.out_last !== prev_last) begin
          failed++;
          $display("FAIL stall_hold: got v=%b out=%h last=%b, need v=1 out=%h last=%b",
                   bus.out_valid, bus.out, bus.out_last, prev_out, prev_last);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_cnt++;
        if (beat_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL beat_unexpected: got out=%h last=%b, need no beat", bus.out, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out} !== e) begin
            failed++;
            $display("FAIL beat_data: got last=%b out=%h, need last=%b out=%h",
                     bus.out_last, bus.out, e[16], e[15:0]);
          end
        end
        rx_word = {rx_word[IN_W-OUT_W-1:0], bus.out};
        rx_n++;
        if (bus.out_last) begin
          if (rt_q.size() > 0) begin
            tests++;
            p = rt_q.pop_front();
            if (rx_word !== p || rx_n != NB) begin
              failed++;
              $display("FAIL round_trip: got %h (%0d beats), need %h (%0d beats)", rx_word, rx_n, p, NB);
            end
          end
          rx_n = 0;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
      prev_last  = bus.out_last;
    end else begin
      prev_stall = 1'b0;
      rx_n       = 0;
    end
  end

  task automatic push_pkt(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] t;
    t = d;
    for (int i = 0; i < int'(NB); i++) begin
      exp_q.push_back({(i == int'(NB) - 1), t[IN_W-1 -: OUT_W]});
      t = t << OUT_W;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance.
  task automatic send_pkt(input logic [IN_W-1:0] d, output int acc);
    acc = -1;
    bus.in       = d;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && acc < 0; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_pkt(d);
        acc = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    tests++;
    if (acc < 0) begin
      failed++;
      $display("FAIL send_timeout: got no accept in 200 cycles, need accept");
    end
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beat_cnt < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    tests++;
    if (beat_cnt != n) begin
      failed++;
      $display("FAIL wait_beats: got %0d beats, need %0d", beat_cnt, n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d beats outstanding, need 0", exp_q.size());
    end
  endtask

  function automatic logic [IN_W-1:0] rand_pkt();
    logic [IN_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(IN_W / 32); i++) r = {r[IN_W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b000) begin
      failed++;
      $display("FAIL reset_state: got rdy/v/last=%b%b%b, need 000",
               bus.in_ready, bus.out_valid, bus.out_last);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: got rdy=%b v=%b, need rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [IN_W-1:0] d;
    int acc;
    d = '0;
    for (int w = 0; w < int'(NB); w++) d = {d[IN_W-OUT_W-1:0], 16'(int'(NB) - 1 - w)};
    bus.out_ready = 1'b1;
    beat_cnt = 0;
    send_pkt(d, acc);
    wait_drain(60);
    tests++;
    if (first_cyc != acc || last_cyc != acc + int'(NB) - 1 || beat_cnt != int'(NB)) begin
      failed++;
      $display("FAIL single_timing: got first=%0d last=%0d n=%0d, need first=%0d last=%0d n=%0d",
               first_cyc, last_cyc, beat_cnt, acc, acc + int'(NB) - 1, NB);
    end
    tests++;
    if (cyc != acc + int'(NB) || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failed++;
      $display("FAIL single_ready_after: got cyc=%0d rdy=%b v=%b, need cyc=%0d rdy=1 v=0",
               cyc, bus.in_ready, bus.out_valid, acc + int'(NB));
    end
  endtask

  task automatic test_random_stall();
    logic [IN_W-1:0] d;
    int acc;
    int k;
    d = '0;
    for (int w = 0; w < int'(NB); w++) d = {d[IN_W-OUT_W-1:0], (w % 2 == 0) ? 16'hA5A5 : 16'h5A5A};
    bus.out_ready = 1'b0;
    beat_cnt = 0;
    send_pkt(d, acc);
    k = 0;
    while (exp_q.size() > 0 && k < 600) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      k++;
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (beat_cnt != int'(NB) || exp_q.size() != 0) begin
      failed++;
      $display("FAIL stall_count: got %0d handshakes (%0d left), need %0d (0 left)",
               beat_cnt, exp_q.size(), NB);
    end
  endtask

  task automatic test_flush();
    int acc;
    bus.out_ready = 1'b1;
    beat_cnt = 0;
    send_pkt(rand_pkt(), acc);
    wait_beats(10);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_q.delete();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      failed++;
      $display("FAIL flush_clear: got v=%b last=%b, need 0 0", bus.out_valid, bus.out_last);
    end
    flush = 1'b1;
    bus.in = '1;
    bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      failed++;
      $display("FAIL flush_in_ready: got %b, need 0", bus.in_ready);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      failed++;
      $display("FAIL flush_no_accept: got v=%b, need 0", bus.out_valid);
    end
    beat_cnt = 0;
    send_pkt({{(IN_W-1){1'b0}}, 1'b1}, acc);
    wait_drain(60);
    tests++;
    if (beat_cnt != int'(NB)) begin
      failed++;
      $display("FAIL flush_next_pkt: got %0d beats, need %0d", beat_cnt, NB);
    end
  endtask

  task automatic test_async_reset();
    int acc;
    int n0;
    bus.out_ready = 1'b1;
    beat_cnt = 0;
    send_pkt(rand_pkt(), acc);
    wait_beats(5);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b000) begin
      failed++;
      $display("FAIL async_reset: got rdy/v/last=%b%b%b, need 000",
               bus.in_ready, bus.out_valid, bus.out_last);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failed++;
      $display("FAIL async_release: got rdy=%b v=%b, need rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    n0 = beat_cnt;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (beat_cnt != n0) begin
      failed++;
      $display("FAIL async_stale: got %0d extra beats, need 0", beat_cnt - n0);
    end
  endtask

  task automatic test_round_trip();
    logic [IN_W-1:0] d;
    int acc;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = rand_pkt();
      rt_q.push_back(d);
      send_pkt(d, acc);
    end
    wait_drain(200);
    tests++;
    if (rt_q.size() != 0) begin
      failed++;
      $display("FAIL round_trip_count: got %0d packets unreturned, need 0", rt_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc_a;
    int acc_b;
    bus.out_ready = 1'b1;
    beat_cnt = 0;
    send_pkt(rand_pkt(), acc_a);
    send_pkt(rand_pkt(), acc_b);
    wait_drain(120);
    tests++;
    if (acc_b - acc_a != B_OFF) begin
      failed++;
      $display("FAIL b2b_accept: got second accept %0d cycles after first, need %0d", acc_b - acc_a, B_OFF);
    end
    tests++;
    if (beat_cnt != 2 * int'(NB) || last_cyc - first_cyc + 1 != B2B_SPAN) begin
      failed++;
      $display("FAIL b2b_span: got %0d beats over %0d cycles, need %0d over %0d",
               beat_cnt, last_cyc - first_cyc + 1, 2 * NB, B2B_SPAN);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in        = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_random_stall();
    test_flush();
    test_async_reset();
    test_round_trip();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
